hamming_ecc_encode_stage: RTL and testbench
===========================================

// Module: hamming_ecc_encode_stage
// PURPOSE
//  Pipelined Hamming SEC/SECDED encoder; the stage directly downstream of the hash core.
//  Takes DATA_W-bit hash words and emits codewords with check bits appended.
//  Codeword and check-bit widths come from ECC_bitsQnty/log2 in G_RD_PROJ_functions.
//  Two register stages with valid/ready flow control, plus a wrapping emitted-codeword counter.
// PARAMETERS
//  DATA_W  32  payload (hash word) width, >=4
//  SECDED  1   1: append overall parity bit (SECDED); 0: plain SEC
//  CNT_W   16  width of the emitted-codeword counter
//  Derived: ECC_W = ECC_bitsQnty(DATA_W) (6 @32); CW_W = DATA_W+ECC_W+SECDED (39 @32)
// PORTS
//  clk       in   1      clock, all state rising-edge
//  rst_n     in   1      asynchronous active-low reset
//  s_valid   in   1      input word valid
//  s_ready   out  1      stage can accept input this cycle
//  s_data    in   DATA_W hash word to encode
//  m_valid   out  1      codeword valid
//  m_ready   in   1      downstream accepts codeword
//  m_code    out  CW_W   encoded codeword
//  cw_count  out  CNT_W  number of codewords accepted downstream, mod 2**CNT_W
// BEHAVIOUR
//  Reset (async, rst_n=0): v1, v2, m_valid, cw_count = 0; m_code = 0. Data regs need no reset.
//  Transfer rules: input xfer = s_valid & s_ready; output xfer = m_valid & m_ready.
//  Stage 2 advances when adv2 = !v2 | m_ready; stage 1 advances when adv1 = !v1 | adv2.
//  s_ready = adv1 (combinational from m_ready; no s_valid->s_ready path).
//  Stage 1 (on adv1): v1 <= s_valid; captures s_data scattered into Hamming positions:
//   positions 1..DATA_W+ECC_W (1-based); powers of two reserved for check bits;
//   data bits fill non-power-of-two positions in ascending order, data bit0 lowest.
//  Stage 2 (on adv2): v2 <= v1; check bit p_k (position 2**k) = XOR of all positions with bit k set;
//   SECDED: bit CW_W-1 = XOR of positions 1..DATA_W+ECC_W (even overall parity).
//  m_code[i] = Hamming position i+1; m_valid = v2. Latency: 2 cycles input xfer -> m_valid.
//  Throughput: 1 word/cycle with m_ready=1; under back-pressure holds up to 2 words, then s_ready=0.
//  m_code and m_valid stable while m_valid & !m_ready (no drop, no duplicate, order kept).
//  Simultaneous output xfer and input xfer on full pipe: both happen same cycle, no bubble.
//  cw_count increments on each output xfer, wraps 2**CNT_W-1 -> 0.
//  Reset mid-operation: in-flight words discarded, m_valid drops immediately (async), counter cleared.
// STRUCTURE
//  G_RD_PROJ_functions: reuse ECC_bitsQnty, log2; add is_pow2(int) function and
//   localparam-friendly function cw_width(DATA_W, SECDED).
//  Sub-module hamming_parity_gen (combinational: scattered vector -> check bits + overall parity),
//   instanced in stage 2; scatter logic and handshake registers stay in this module.
// TESTING
//  Reset: rst_n=0 -> m_valid=0, cw_count=0, s_ready=1 after release.
//  DATA_W=32, s_data=32'h0 -> after 2 cycles m_code=39'h0, cw_count=1.
//  s_data=32'h1 -> m_code=39'h40_0000_0007 (pos1,2,3 set; overall parity bit 38 = 1).
//  Random data stream, m_ready=1 -> one codeword/cycle; scoreboard vs software encoder; single-bit
//   flip of each codeword gives nonzero syndrome equal to flipped position.
//  m_ready=0 for 5 cycles, 3 words offered -> 2 held, s_ready=0, third stalls; release -> 3 in order.
//  CNT_W=4, 17 words -> cw_count wraps 15->0, reads 1; rst_n pulse mid-stream -> m_valid=0 at once.

Source files
------------

// File: rtl/hamming_ecc_encode_stage_pkg.sv
// Width helpers for the Hamming ECC encoder stage.
// Pure constant functions, usable in localparam expressions.
package hamming_ecc_encode_stage_pkg;

  function automatic int log2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < n) r = i + 1;
    return r;
  endfunction

  // Smallest r with 2**r >= d + r + 1
  function automatic int ECC_bitsQnty(input int d);
    int r;
    r = 0;
    for (int i = 30; i >= 1; i--)
      if ((1 << i) >= d + i + 1) r = i;
    return r;
  endfunction

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

  function automatic int cw_width(
    input int d,
    input int secded
  );
    return d + ECC_bitsQnty(d) + secded;
  endfunction

endpackage

// File: rtl/hamming_ecc_encode_stage_parity.sv
// Combinational Hamming check-bit and overall-parity generator.
// vec[i] holds Hamming position i+1; check positions arrive as zero.
module hamming_parity_gen #(
  parameter int HW    = 38,
  parameter int ECC_W = 6
) (
  input  logic [HW-1:0]    vec,
  output logic [ECC_W-1:0] chk,
  output logic             par
);

  always_comb begin
    chk = '0;
    for (int k = 0; k < ECC_W; k++)
      for (int i = 0; i < HW; i++)
        if (((i + 1) & (1 << k)) != 0)
          chk[k] = chk[k] ^ vec[i];
    par = (^vec) ^ (^chk);
  end

endmodule

// File: rtl/hamming_ecc_encode_stage.sv
// Two-stage pipelined Hamming SEC/SECDED encoder with
// valid/ready flow control and an emitted-codeword counter.
module hamming_ecc_encode_stage
  import hamming_ecc_encode_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int SECDED = 1,
  parameter int CNT_W  = 16,
  localparam int ECC_W = ECC_bitsQnty(DATA_W),
  localparam int HW    = DATA_W + ECC_W,
  localparam int CW_W  = cw_width(DATA_W, SECDED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CW_W-1:0]   m_code,
  output logic [CNT_W-1:0]  cw_count
);

  logic             v1;
  logic             v2;
  logic             adv1;
  logic             adv2;
  logic [HW-1:0]    scat;
  logic [HW-1:0]    s1_vec;
  logic [ECC_W-1:0] chk;
  logic             par;
  logic [HW:0]      code_nxt;

  assign adv2    = !v2 || m_ready;
  assign adv1    = !v1 || adv2;
  assign s_ready = adv1;
  assign m_valid = v2;

  // Data bits fill non-power-of-two positions, bit0 lowest
  always_comb begin
    int j;
    j    = 0;
    scat = '0;
    for (int p = 1; p <= HW; p++)
      if (!is_pow2(p)) begin
        scat[p-1] = s_data[j];
        j++;
      end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      v1 <= 1'b0;
    else if (adv1)
      v1 <= s_valid;

  always_ff @(posedge clk)
    if (adv1)
      s1_vec <= scat;

  hamming_parity_gen #(
    .HW    (HW),
    .ECC_W (ECC_W)
  ) u_parity (
    .vec (s1_vec),
    .chk (chk),
    .par (par)
  );

  always_comb begin
    code_nxt = {1'b0, s1_vec};
    for (int k = 0; k < ECC_W; k++)
      code_nxt[(1 << k) - 1] = chk[k];
    code_nxt[HW] = par;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      v2     <= 1'b0;
      m_code <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1)
        m_code <= code_nxt[CW_W-1:0];
    end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      cw_count <= '0;
    else if (m_valid && m_ready)
      cw_count <= cw_count + 1'b1;

endmodule

// File: tb/tb_hamming_ecc_encode_stage.sv
// Randomized self-checking bench for hamming_ecc_encode_stage.
// Reference encoder works from position syndromes, not gate equations.
module tb_hamming_ecc_encode_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        m_ready = 1'b0;

  logic        s_ready;
  logic        m_valid;
  logic [38:0] m_code;
  logic [15:0] cw_count;
  logic        s_ready4;
  logic        m_valid4;
  logic [38:0] m_code4;
  logic [3:0]  cw_count4;

  int n_chk = 0;
  int n_fail = 0;

  logic [38:0] exp_q[$];
  int          model_cnt = 0;
  logic        in_x;
  logic        out_x;
  logic        exp_ok;
  logic [38:0] exp_code;
  int          exp_cnt;

  hamming_ecc_encode_stage dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_code   (m_code),
    .cw_count (cw_count)
  );

  hamming_ecc_encode_stage #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready4),
    .s_data   (s_data),
    .m_valid  (m_valid4),
    .m_ready  (m_ready),
    .m_code   (m_code4),
    .cw_count (cw_count4)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit 100000", $time);
    $fatal(1, "watchdog");
  end

  // Check bits are chosen so XOR of all set positions is zero
  function automatic logic [38:0] enc(input logic [31:0] d);
    logic [38:0] c;
    int j;
    int s;
    c = '0;
    j = 0;
    s = 0;
    for (int p = 1; p <= 38; p++)
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[j];
        if (d[j]) s = s ^ p;
        j++;
      end
    for (int k = 0; k < 6; k++)
      c[(1 << k) - 1] = s[k];
    c[38] = ^c[37:0];
    return c;
  endfunction

  function automatic int syn(input logic [38:0] c);
    int s;
    s = 0;
    for (int p = 1; p <= 38; p++)
      if (c[p-1]) s = s ^ p;
    return s;
  endfunction

  task automatic tick(
    input logic        v,
    input logic [31:0] d,
    input logic        r
  );
    @(posedge clk);
    #1;
    s_valid = v;
    s_data  = d;
    m_ready = r;
    @(negedge clk);
    in_x    = s_valid && s_ready;
    out_x   = m_valid && m_ready;
    exp_ok  = 1'b0;
    exp_cnt = model_cnt;
    if (out_x && exp_q.size() > 0) begin
      exp_code = exp_q.pop_front();
      exp_ok   = 1'b1;
    end
    if (out_x) model_cnt++;
    if (in_x) exp_q.push_back(enc(d));
  endtask

  task automatic test_reset();
    #1;
    n_chk++;
    if (m_valid !== 1'b0 || m_valid4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", m_valid);
    end
    n_chk++;
    if (cw_count !== 16'd0 || cw_count4 !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_count: got %0d/%0d want 0", cw_count, cw_count4);
    end
    n_chk++;
    if (m_code !== 39'h0) begin
      n_fail++;
      $display("FAIL reset_code: got %h want 0", m_code);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(negedge clk);
    n_chk++;
    if (s_ready !== 1'b1 || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: s_ready %b m_valid %b want 1 0", s_ready, m_valid);
    end
  endtask

  task automatic test_known(input logic [31:0] d, input logic [38:0] cw, input int cnt);
    tick(1'b1, d, 1'b1);
    n_chk++;
    if (in_x !== 1'b1) begin
      n_fail++;
      $display("FAIL known_accept: s_ready %b want 1", s_ready);
    end
    tick(1'b0, '0, 1'b1);
    n_chk++;
    if (m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL known_latency1: m_valid %b want 0", m_valid);
    end
    tick(1'b0, '0, 1'b1);
    n_chk++;
    if (m_valid !== 1'b1 || m_code !== cw) begin
      n_fail++;
      $display("FAIL known_code: m_valid %b code %h want 1 %h", m_valid, m_code, cw);
    end
    n_chk++;
    if (!exp_ok || m_code !== exp_code) begin
      n_fail++;
      $display("FAIL known_model: got %h want %h", m_code, exp_code);
    end
    tick(1'b0, '0, 1'b1);
    n_chk++;
    if (cw_count !== 16'(cnt) || m_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL known_count: got %0d valid %b want %0d 0", cw_count, m_valid, cnt);
    end
  endtask

  task automatic test_stream(input int n);
    int pos;
    int want;
    logic [38:0] f;
    for (int i = 0; i < n + 4; i++) begin
      tick(i < n, $urandom, 1'b1);
      if (i >= 2 && i < n + 2) begin
        n_chk++;
        if (m_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_rate: cycle %0d m_valid %b want 1", i, m_valid);
        end
      end
      if (out_x) begin
        n_chk++;
        if (!exp_ok || m_code !== exp_code || m_code4 !== exp_code) begin
          n_fail++;
          $display("FAIL stream_code: got %h want %h", m_code, exp_code);
        end
        n_chk++;
        if (cw_count !== exp_cnt[15:0] || cw_count4 !== exp_cnt[3:0]) begin
          n_fail++;
          $display("FAIL stream_count: got %0d want %0d", cw_count, exp_cnt[15:0]);
        end
        pos  = int'($urandom_range(1, 39));
        f    = m_code ^ (39'h1 << (pos - 1));
        want = (pos <= 38) ? pos : 0;
        n_chk++;
        if (syn(f) != want || (^f) !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_syndrome: got %0d want %0d", syn(f), want);
        end
      end
    end
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_drain: %0d words left want 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] w[3];
    int n_out;
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    n_out = 0;
    tick(1'b1, w[0], 1'b0);
    tick(1'b1, w[1], 1'b0);
    n_chk++;
    if (in_x !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_second: s_ready %b want 1", s_ready);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, w[2], 1'b0);
      n_chk++;
      if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_code !== enc(w[0])) begin
        n_fail++;
        $display("FAIL bp_hold: s_ready %b valid %b code %h want 0 1 %h",
                 s_ready, m_valid, m_code, enc(w[0]));
      end
    end
    tick(1'b1, w[2], 1'b1);
    n_chk++;
    if (in_x !== 1'b1 || out_x !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_simul: in %b out %b want 1 1", in_x, out_x);
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick(1'b0, '0, 1'b1);
      if (out_x) begin
        n_out++;
        n_chk++;
        if (!exp_ok || m_code !== exp_code) begin
          n_fail++;
          $display("FAIL bp_order: got %h want %h", m_code, exp_code);
        end
      end
    end
    n_chk++;
    if (n_out != 3 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count: got %0d words want 3", n_out);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 21; i++) begin
      tick(i < 17, $urandom, 1'b1);
      if (out_x) begin
        n_chk++;
        if (cw_count4 !== exp_cnt[3:0] || m_code4 !== exp_code) begin
          n_fail++;
          $display("FAIL wrap_step: got %0d want %0d", cw_count4, exp_cnt[3:0]);
        end
      end
    end
    n_chk++;
    if (cw_count4 !== 4'd1 || cw_count !== 16'd17) begin
      n_fail++;
      $display("FAIL wrap_final: got %0d/%0d want 1/17", cw_count4, cw_count);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) tick(1'b1, $urandom, 1'b1);
    n_chk++;
    if (m_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_prefill: m_valid %b want 1", m_valid);
    end
    #2;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    n_chk++;
    if (m_valid !== 1'b0 || cw_count !== 16'd0 || cw_count4 !== 4'd0) begin
      n_fail++;
      $display("FAIL mid_async: valid %b count %0d want 0 0", m_valid, cw_count);
    end
    exp_q.delete();
    model_cnt = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, '0, 1'b1);
      n_chk++;
      if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_flush: valid %b ready %b want 0 1", m_valid, s_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_known(32'h0, 39'h0, 1);
    test_known(32'h1, 39'h40_0000_0007, 2);
    test_stream(200);
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
